// File: rtl/port_arb_pkg.sv
// Shared types and helpers for the packet-granular round-robin write-channel arbiter.
package port_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int PORTNUM_DEF = 16;
  localparam int PORTNUM_MAX = 256;

  // Callers narrow the result to their own port count with a size cast.
  function automatic logic [PORTNUM_MAX-1:0] onehot(input int unsigned idx);
    return PORTNUM_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester strictly above ptr, else lowest overall.
module rr_pick
  import port_arb_pkg::*;
#(
  parameter  int PORTNUM = PORTNUM_DEF,
  localparam int SELW    = $clog2(PORTNUM)
) (
  input  logic [PORTNUM-1:0] req,
  input  logic [SELW-1:0]    ptr,
  output logic               vld,
  output logic [SELW-1:0]    idx
);

  logic [PORTNUM-1:0] mask;
  logic [PORTNUM-1:0] masked;
  logic [SELW-1:0]    m_idx;
  logic [SELW-1:0]    u_idx;
  logic               m_found;
  logic               u_found;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PORTNUM; i++) begin
      mask[i] = (i > 32'(ptr));
    end
    masked = req & mask;
  end

  always_comb begin
    m_idx   = '0;
    u_idx   = '0;
    m_found = 1'b0;
    u_found = 1'b0;
    for (int unsigned i = 0; i < PORTNUM; i++) begin
      if (masked[i] && !m_found) begin
        m_idx   = SELW'(i);
        m_found = 1'b1;
      end
      if (req[i] && !u_found) begin
        u_idx   = SELW'(i);
        u_found = 1'b1;
      end
    end
  end

  assign vld = |req;
  assign idx = m_found ? m_idx : u_idx;

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-granular round-robin arbiter for the shared cache write channel, with a
// watchdog that force-releases a grant whose packet never signals end-of-packet.
module rr_packet_arbiter
  import port_arb_pkg::*;
#(
  parameter  int PORTNUM     = PORTNUM_DEF,
  parameter  int MAX_PKT_CYC = 1024,
  localparam int SELW        = $clog2(PORTNUM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PORTNUM-1:0] i_req,
  input  logic               i_eop,
  input  logic               i_ready,
  output logic               o_port_ready,
  output logic [PORTNUM-1:0] o_resp,
  output logic [PORTNUM-1:0] o_nresp,
  output logic               o_en,
  output logic [SELW-1:0]    o_sel,
  output logic               o_timeout
);

  localparam int              WDW     = $clog2(MAX_PKT_CYC) + 1;
  localparam logic [WDW-1:0]  WD_LAST = WDW'(MAX_PKT_CYC - 1);

  arb_state_t         state_q, state_d;
  logic [SELW-1:0]    ptr_q, ptr_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic [PORTNUM-1:0] resp_q, resp_d;
  logic               en_q, en_d;
  logic [SELW-1:0]    sel_q, sel_d;
  logic               timeout_q, timeout_d;

  logic               pick_vld;
  logic [SELW-1:0]    pick_idx;

  rr_pick #(
    .PORTNUM (PORTNUM)
  ) u_pick (
    .req (i_req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= SELW'(PORTNUM - 1);
      wd_q      <= '0;
      resp_q    <= '0;
      en_q      <= 1'b0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      resp_q    <= resp_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    resp_d    = '0;
    en_d      = en_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld && i_ready) begin
          state_d = ARB_BUSY;
          resp_d  = PORTNUM'(onehot(32'(pick_idx)));
          sel_d   = pick_idx;
          en_d    = 1'b1;
          ptr_d   = pick_idx;
          wd_d    = '0;
        end
      end
      ARB_BUSY: begin
        // eop takes precedence over an expiring watchdog; ptr is left on the
        // stalled port in both cases so it drops to lowest priority.
        if (i_eop) begin
          state_d = ARB_IDLE;
          en_d    = 1'b0;
          wd_d    = '0;
        end else if (wd_q >= WD_LAST) begin
          state_d   = ARB_IDLE;
          en_d      = 1'b0;
          wd_d      = '0;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        en_d    = 1'b0;
        wd_d    = '0;
      end
    endcase
  end

  always_comb begin
    o_port_ready = (state_q == ARB_IDLE);
    o_resp       = resp_q;
    o_nresp      = ~resp_q;
    o_en         = en_q;
    o_sel        = sel_q;
    o_timeout    = timeout_q;
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter against a cycle-level behavioural reference model.
module tb_rr_packet_arbiter;

  localparam int N   = 16;
  localparam int MAX = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         eop;
  logic         ready;
  logic         o_port_ready;
  logic [N-1:0] o_resp;
  logic [N-1:0] o_nresp;
  logic         o_en;
  logic [3:0]   o_sel;
  logic         o_timeout;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit           m_busy;
  int           m_last;
  int           m_sel;
  int           m_age;
  logic [N-1:0] m_resp;
  bit           m_en;
  bit           m_to;

  always #5 clk = ~clk;

  rr_packet_arbiter #(
    .PORTNUM     (N),
    .MAX_PKT_CYC (MAX)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_eop        (eop),
    .i_ready      (ready),
    .o_port_ready (o_port_ready),
    .o_resp       (o_resp),
    .o_nresp      (o_nresp),
    .o_en         (o_en),
    .o_sel        (o_sel),
    .o_timeout    (o_timeout)
  );

  task automatic model_reset();
    m_busy = 0; m_last = N - 1; m_sel = 0; m_age = 0;
    m_resp = '0; m_en = 0; m_to = 0;
  endtask

  // One clock: inputs were set at least 1 time unit earlier and are what the DUT samples.
  task automatic tick();
    int  p;
    bit  found;
    @(posedge clk);
    m_resp = '0;
    m_to   = 0;
    if (!m_busy) begin
      if (req != '0 && ready) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          p = (m_last + k) % N;
          if (req[p] && !found) begin
            found  = 1;
            m_busy = 1; m_last = p; m_sel = p; m_age = 0;
            m_resp = '0; m_resp[p] = 1'b1; m_en = 1;
          end
        end
      end
    end else if (eop) begin
      m_busy = 0; m_en = 0;
    end else begin
      m_age++;
      if (m_age == MAX) begin
        m_busy = 0; m_en = 0; m_to = 1;
      end
    end
    #1;
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; eop = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [38:0] got, exp;
    rst = 1'b1; req = '0; eop = 1'b0; ready = 1'b0;
    #3;
    model_reset();
    got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
    exp = {1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'hFFFF};
    total++; if (got !== exp) begin bad++; $display("FAIL reset_values got=%h exp=%h", got, exp); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
    exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
    total++; if (got !== exp) begin bad++; $display("FAIL reset_idle got=%h exp=%h", got, exp); end
  endtask

  task automatic test_single();
    logic [38:0] got, exp;
    req = 16'h0001; ready = 1'b1;
    tick();
    total++;
    if (o_resp !== 16'h0001 || o_nresp !== 16'hFFFE || o_sel !== 4'd0 || o_en !== 1'b1 || o_port_ready !== 1'b0) begin
      bad++; $display("FAIL single_grant resp=%h nresp=%h sel=%0d en=%b rdy=%b exp 0001 FFFE 0 1 0",
                      o_resp, o_nresp, o_sel, o_en, o_port_ready);
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
      exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
      total++; if (got !== exp) begin bad++; $display("FAIL single_busy%0d got=%h exp=%h", i, got, exp); end
    end
    eop = 1'b1;
    tick();
    eop = 1'b0;
    total++;
    if (o_port_ready !== 1'b1 || o_en !== 1'b0 || o_sel !== 4'd0) begin
      bad++; $display("FAIL single_release rdy=%b en=%b sel=%0d exp 1 0 0", o_port_ready, o_en, o_sel);
    end
  endtask

  task automatic test_round_robin();
    logic [38:0] got, exp;
    logic [N-1:0] served;
    int grants, bc, w;
    do_reset();
    req = 16'hFFFF; ready = 1'b1; served = '0; grants = 0; bc = 0;
    for (int cyc = 0; cyc < 200 && grants < 17; cyc++) begin
      tick();
      got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
      exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
      total++; if (got !== exp) begin bad++; $display("FAIL rr_cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (o_resp != '0) begin
        w = idx_of(o_resp);
        total++;
        if (w != grants % N) begin bad++; $display("FAIL rr_order grant%0d port=%0d exp=%0d", grants, w, grants % N); end
        if (served == '1) served = '0;
        total++;
        if (w >= 0 && served[w]) begin bad++; $display("FAIL rr_fair port=%0d regranted served=%h", w, served); end
        if (w >= 0) served[w] = 1'b1;
        grants++;
        bc = 1;
      end else if (m_busy) begin
        bc++;
      end
      eop = m_busy && (bc == 4);
    end
    eop = 1'b0;
    total++; if (grants != 17) begin bad++; $display("FAIL rr_count grants=%0d exp=17", grants); end
  endtask

  task automatic test_wrap();
    logic [38:0] got, exp;
    int seen[$];
    req = 16'h8001; ready = 1'b1;
    eop = m_busy;
    for (int cyc = 0; cyc < 12 && seen.size() < 2; cyc++) begin
      tick();
      got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
      exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
      total++; if (got !== exp) begin bad++; $display("FAIL wrap_cyc%0d got=%h exp=%h", cyc, got, exp); end
      if (o_resp != '0) seen.push_back(idx_of(o_resp));
      eop = m_busy;
    end
    total++;
    if (seen.size() != 2 || seen[0] != 15 || seen[1] != 0) begin
      bad++; $display("FAIL wrap_seq n=%0d first=%0d second=%0d exp 15 0", seen.size(),
                      (seen.size() > 0) ? seen[0] : -1, (seen.size() > 1) ? seen[1] : -1);
    end
    tick();
    eop = 1'b0;
  endtask

  task automatic test_ready_gate();
    logic [38:0] got, exp;
    req = 16'h0010; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
      exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
      total++;
      if (got !== exp || o_resp !== '0) begin bad++; $display("FAIL gate_low%0d got=%h exp=%h", i, got, exp); end
    end
    ready = 1'b1;
    tick();
    total++;
    if (o_resp !== 16'h0010 || o_sel !== 4'd4 || o_en !== 1'b1) begin
      bad++; $display("FAIL gate_grant resp=%h sel=%0d en=%b exp 0010 4 1", o_resp, o_sel, o_en);
    end
    eop = 1'b1;
    tick();
    eop = 1'b0;
  endtask

  task automatic test_timeout();
    logic [38:0] got, exp;
    int n;
    bit hit;
    req = 16'h0008; ready = 1'b1;
    tick();
    total++; if (o_resp !== 16'h0008) begin bad++; $display("FAIL to_grant resp=%h exp=0008", o_resp); end
    req = '0; n = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      n++;
      got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
      exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
      total++; if (got !== exp) begin bad++; $display("FAIL to_cyc%0d got=%h exp=%h", i, got, exp); end
      hit = o_timeout;
    end
    total++;
    if (!hit || n != MAX || o_en !== 1'b0) begin
      bad++; $display("FAIL to_latency seen=%0d cycles=%0d en=%b exp 1 %0d 0", hit, n, o_en, MAX);
    end
    req = 16'h0018;
    tick();
    total++;
    if (o_resp !== 16'h0010 || o_timeout !== 1'b0) begin
      bad++; $display("FAIL to_next resp=%h to=%b exp 0010 0", o_resp, o_timeout);
    end
    req = '0; eop = 1'b1;
    tick();
    eop = 1'b0;
  endtask

  task automatic test_eop_at_expiry();
    logic [38:0] got, exp;
    req = 16'h0001; ready = 1'b1;
    tick();
    req = '0;
    for (int i = 0; i < MAX - 1; i++) tick();
    eop = 1'b1;
    tick();
    eop = 1'b0;
    got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
    exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
    total++;
    if (got !== exp || o_en !== 1'b0 || o_timeout !== 1'b0) begin
      bad++; $display("FAIL eop_expiry got=%h exp=%h", got, exp);
    end
    tick();
    total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL eop_expiry_late to=%b exp=0", o_timeout); end
  endtask

  task automatic test_reset_mid();
    logic [38:0] got, exp;
    req = 16'h0004; ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #2;
    model_reset();
    got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
    exp = {1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'hFFFF};
    total++; if (got !== exp) begin bad++; $display("FAIL reset_async got=%h exp=%h", got, exp); end
    @(posedge clk); #1;
    rst = 1'b0; req = 16'hFFFF;
    tick();
    total++; if (o_resp !== 16'h0001) begin bad++; $display("FAIL reset_ptr resp=%h exp=0001", o_resp); end
    req = '0; eop = 1'b1;
    tick();
    eop = 1'b0;
  endtask

  task automatic test_random();
    logic [38:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = N'($urandom) & N'($urandom) & N'($urandom);
        default: req = N'($urandom);
      endcase
      ready = ($urandom_range(0, 3) != 0);
      eop   = ($urandom_range(0, 5) == 0);
      tick();
      got = {o_port_ready, o_en, o_timeout, o_sel, o_resp, o_nresp};
      exp = {~m_busy, m_en, m_to, 4'(m_sel), m_resp, ~m_resp};
      total++; if (got !== exp) begin bad++; $display("FAIL rand_cyc%0d got=%h exp=%h", i, got, exp); end
    end
    eop = 1'b0; req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_ready_gate();
    test_timeout();
    test_eop_at_expiry();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
